// File: rtl/seq_recognizer.sv
// -----------------------------------------------------------------------------
// seq_recognizer
//
// Parametrised serial-sequence recognizer. Watches a 1-bit serial stream,
// qualified by a valid strobe, for an N-bit PATTERN that arrives MSB first.
// The match indication Q is Mealy, so it is visible in the same cycle as the
// completing bit. A saturating counter records the number of matches.
// All state updates happen on the FALLING edge of clk.
//
// Parameters
//   N        pattern length in bits (2..16)
//   PATTERN  N-bit pattern; PATTERN[N-1] is the first bit expected
//   OVERLAP  1: after a match, resume from the longest proper prefix-suffix
//            0: after a match, restart from the empty prefix
//   COUNT_W  width of match_count
//
// Ports
//   clk          system clock; state updates on the falling edge
//   reset        asynchronous active-low reset (clears state and counter)
//   valid        D is sampled only while valid is high
//   D            serial data bit
//   clear        synchronous counter clear; wins over a simultaneous match
//   Q            Mealy match: valid & (state == N-1) & (D == PATTERN[0])
//   match_count  saturating number of matches since reset/clear
//   state        current matched-prefix length k (debug)
// -----------------------------------------------------------------------------
module seq_recognizer #(
  parameter int          N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b011,
  parameter bit          OVERLAP = 1'b1,
  parameter int          COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 D,
  input  logic                 clear,
  output logic                 Q,
  output logic [COUNT_W-1:0]   match_count,
  output logic [$clog2(N)-1:0] state
);

  localparam int            SW       = $clog2(N);
  // Every encoding of the state register gets a table entry, so encodings
  // >= N (unreachable in normal operation) have a defined successor of 0.
  localparam int            NS       = 1 << SW;
  localparam logic [SW-1:0] K_LAST   = SW'(N - 1);
  localparam logic          LAST_BIT = PATTERN[0];

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input int i);
    return PATTERN[N-1-i];
  endfunction

  // Successor of prefix length k after receiving bit d.
  // The received history is "first k pattern bits, then d" (length k+1);
  // the successor is the longest suffix of that string, shorter than N,
  // which is also a prefix of PATTERN. On a full match this is F(N) for
  // overlapping mode; non-overlapping mode forces 0 instead.
  function automatic logic [SW-1:0] next_k(input int k, input logic d);
    int   best;
    int   j;
    logic ok;
    logic sb;
    best = 0;
    if (k >= N) begin
      return '0;
    end
    if (!OVERLAP && (k == N - 1) && (d == pat_bit(N - 1))) begin
      return '0;
    end
    for (int len = 1; len < N; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < len; i++) begin
          j  = k + 1 - len + i;
          sb = (j < k) ? pat_bit(j) : d;
          if (sb != pat_bit(i)) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          best = len;
        end
      end
    end
    return SW'(best);
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  // Transition constants, one pair per state encoding, fixed at elaboration.
  logic [SW-1:0] nx_d0 [NS];
  logic [SW-1:0] nx_d1 [NS];

  for (genvar g = 0; g < NS; g++) begin : g_trans
    localparam logic [SW-1:0] NX0 = next_k(g, 1'b0);
    localparam logic [SW-1:0] NX1 = next_k(g, 1'b1);
    assign nx_d0[g] = NX0;
    assign nx_d1[g] = NX1;
  end

  logic [SW-1:0]      k_q;
  logic [SW-1:0]      k_nxt;
  logic               match;
  logic [COUNT_W-1:0] cnt_q;

  // Next-state and Mealy output
  always_comb begin
    k_nxt = k_q;
    match = 1'b0;
    if (valid) begin
      match = (k_q == K_LAST) && (D == LAST_BIT);
      k_nxt = D ? nx_d1[k_q] : nx_d0[k_q];
    end
  end

  // State register (falling edge)
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      k_q <= '0;
    end else begin
      k_q <= k_nxt;
    end
  end

  // Match counter: clear has priority over a same-edge match
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (match) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign Q           = match;
  assign match_count = cnt_q;
  assign state       = k_q;

endmodule

// File: tb/tb_seq_recognizer.sv
// -----------------------------------------------------------------------------
// tb_seq_recognizer
//
// Five recognizer instances with different parameter sets share one stimulus
// stream. A string-history reference model per instance predicts Q, state
// and match_count. Inputs change on the rising edge (the DUT acts on the
// falling edge) and outputs are sampled 1 time unit after each edge.
//   inst 0: N=3 PATTERN=011  OVERLAP=1 COUNT_W=8
//   inst 1: N=4 PATTERN=1010 OVERLAP=1 COUNT_W=8
//   inst 2: N=4 PATTERN=1010 OVERLAP=0 COUNT_W=8
//   inst 3: N=4 PATTERN=1101 OVERLAP=1 COUNT_W=8
//   inst 4: N=3 PATTERN=011  OVERLAP=1 COUNT_W=2
// -----------------------------------------------------------------------------
module tb_seq_recognizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, valid, D, clear;

  logic       q0, q1, q2, q3, q4;
  logic [1:0] s0, s1, s2, s3, s4;
  logic [7:0] c0, c1, c2, c3;
  logic [1:0] c4;

  seq_recognizer #(.N(3), .PATTERN(3'b011), .OVERLAP(1'b1), .COUNT_W(8)) u0 (
    .clk(clk), .reset(reset), .valid(valid), .D(D), .clear(clear),
    .Q(q0), .match_count(c0), .state(s0));
  seq_recognizer #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .COUNT_W(8)) u1 (
    .clk(clk), .reset(reset), .valid(valid), .D(D), .clear(clear),
    .Q(q1), .match_count(c1), .state(s1));
  seq_recognizer #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .COUNT_W(8)) u2 (
    .clk(clk), .reset(reset), .valid(valid), .D(D), .clear(clear),
    .Q(q2), .match_count(c2), .state(s2));
  seq_recognizer #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .COUNT_W(8)) u3 (
    .clk(clk), .reset(reset), .valid(valid), .D(D), .clear(clear),
    .Q(q3), .match_count(c3), .state(s3));
  seq_recognizer #(.N(3), .PATTERN(3'b011), .OVERLAP(1'b1), .COUNT_W(2)) u4 (
    .clk(clk), .reset(reset), .valid(valid), .D(D), .clear(clear),
    .Q(q4), .match_count(c4), .state(s4));

  logic        q_act   [5];
  logic [31:0] st_act  [5];
  logic [31:0] cnt_act [5];

  always_comb begin
    q_act[0] = q0; q_act[1] = q1; q_act[2] = q2; q_act[3] = q3; q_act[4] = q4;
    st_act[0] = {30'b0, s0}; st_act[1] = {30'b0, s1}; st_act[2] = {30'b0, s2};
    st_act[3] = {30'b0, s3}; st_act[4] = {30'b0, s4};
    cnt_act[0] = {24'b0, c0}; cnt_act[1] = {24'b0, c1}; cnt_act[2] = {24'b0, c2};
    cnt_act[3] = {24'b0, c3}; cnt_act[4] = {30'b0, c4};
  end

  // Reference model parameters
  int m_n   [5] = '{3, 4, 4, 4, 3};
  int m_pat [5] = '{3, 10, 10, 13, 3};
  bit m_ov  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int m_max [5] = '{255, 255, 255, 255, 3};

  // Reference model state: received bits (newest in bit 0) since reset or,
  // in non-overlapping mode, since the last match; plus the match count.
  int m_hist [5];
  int m_len  [5];
  int m_cnt  [5];
  bit exp_q  [5];

  int checks = 0;
  int errors = 0;

  function automatic int model_k(input int i);
    int best;
    best = 0;
    for (int l = 1; l < m_n[i]; l++) begin
      if (l <= m_len[i] &&
          ((m_hist[i] & ((1 << l) - 1)) == (m_pat[i] >> (m_n[i] - l))))
        best = l;
    end
    return best;
  endfunction

  function automatic bit model_q(input int i, input bit v, input bit d);
    int cand;
    cand = (m_hist[i] << 1) | int'(d);
    return v && (m_len[i] + 1 >= m_n[i]) &&
           ((cand & ((1 << m_n[i]) - 1)) == m_pat[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_hist[i] = 0; m_len[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit q;
    for (int i = 0; i < 5; i++) begin
      q = model_q(i, valid, D);
      if (clear) m_cnt[i] = 0;
      else if (q && m_cnt[i] < m_max[i]) m_cnt[i]++;
      if (valid) begin
        if (q && !m_ov[i]) begin
          m_hist[i] = 0; m_len[i] = 0;
        end else begin
          m_hist[i] = (m_hist[i] << 1) | int'(D);
          if (m_len[i] < 32) m_len[i]++;
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    reset = 1'b0; valid = 1'b0; D = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge clk);
    @(posedge clk);
    reset = 1'b1;
  endtask

  // Drives one step per bit (bit len-1 first) and checks every instance
  // before and after the falling edge.
  task automatic run_seq(input logic [63:0] vb, input logic [63:0] db,
                         input logic [63:0] cb, input int len);
    for (int s = len - 1; s >= 0; s--) begin
      @(posedge clk);
      valid = vb[s]; D = db[s]; clear = cb[s];
      #1;
      for (int i = 0; i < 5; i++) begin
        exp_q[i] = model_q(i, valid, D);
        checks++;
        if (q_act[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL q inst%0d step%0d got %b exp %b", i, s, q_act[i], exp_q[i]);
        end
      end
      @(negedge clk);
      model_edge();
      #1;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (st_act[i] !== 32'(model_k(i))) begin
          errors++;
          $display("FAIL state inst%0d step%0d got %0d exp %0d", i, s, st_act[i], model_k(i));
        end
        checks++;
        if (cnt_act[i] !== 32'(m_cnt[i])) begin
          errors++;
          $display("FAIL count inst%0d step%0d got %0d exp %0d", i, s, cnt_act[i], m_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b1; D = 1'b1; clear = 1'b0;
    model_reset();
    #3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (q_act[i] !== 1'b0 || st_act[i] !== 32'd0 || cnt_act[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset inst%0d got q=%b k=%0d cnt=%0d exp 0/0/0",
                 i, q_act[i], st_act[i], cnt_act[i]);
      end
    end
    @(posedge clk);
    reset = 1'b1; valid = 1'b0;
  endtask

  task automatic test_basic_stream();
    apply_reset();
    run_seq('1, 64'b1011011, '0, 7);
    checks++;
    if (c0 !== 8'd2 || s0 !== 2'd0) begin
      errors++;
      $display("FAIL basic_011 got cnt=%0d k=%0d exp cnt=2 k=0", c0, s0);
    end
  endtask

  task automatic test_overlap_modes();
    apply_reset();
    run_seq('1, 64'b10101010, '0, 8);
    checks++;
    if (c1 !== 8'd3) begin
      errors++;
      $display("FAIL overlap_1010 got %0d exp 3", c1);
    end
    checks++;
    if (c2 !== 8'd2) begin
      errors++;
      $display("FAIL nonoverlap_1010 got %0d exp 2", c2);
    end
  endtask

  task automatic test_mismatch_fallback();
    apply_reset();
    run_seq('1, 64'b11101, '0, 5);
    checks++;
    if (c3 !== 8'd1 || s3 !== 2'd1) begin
      errors++;
      $display("FAIL fallback_1101 got cnt=%0d k=%0d exp cnt=1 k=1", c3, s3);
    end
    apply_reset();
    run_seq('1, 64'b1100, '0, 4);
    checks++;
    if (s3 !== 2'd0) begin
      errors++;
      $display("FAIL fallback_1100 got k=%0d exp 0", s3);
    end
  endtask

  task automatic test_valid_gap();
    apply_reset();
    run_seq(64'b11000001, 64'b01101011, '0, 8);
    checks++;
    if (c0 !== 8'd1 || s0 !== 2'd0) begin
      errors++;
      $display("FAIL valid_gap got cnt=%0d k=%0d exp cnt=1 k=0", c0, s0);
    end
  endtask

  task automatic test_saturation_clear();
    apply_reset();
    run_seq('1, 64'b011011011011011, '0, 15);
    checks++;
    if (c4 !== 2'd3) begin
      errors++;
      $display("FAIL saturate got %0d exp 3", c4);
    end
    run_seq('1, 64'b011, 64'b001, 3);
    checks++;
    if (c4 !== 2'd0 || c0 !== 8'd0) begin
      errors++;
      $display("FAIL clear_wins got cnt4=%0d cnt0=%0d exp 0/0", c4, c0);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    run_seq('1, 64'b01101, '0, 5);
    @(posedge clk);
    valid = 1'b1; D = 1'b1; clear = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (s0 !== 2'd0 || c0 !== 8'd0 || q0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got k=%0d cnt=%0d q=%b exp 0/0/0", s0, c0, q0);
    end
    model_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (q0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_q got %b exp 0", q0);
    end
    @(negedge clk);
    model_edge();
    #1;
    checks++;
    if (s0 !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_k got %0d exp 0", s0);
    end
    run_seq('1, 64'b011, '0, 3);
  endtask

  task automatic test_random();
    logic [63:0] vb, db, cb;
    apply_reset();
    for (int r = 0; r < 10; r++) begin
      for (int b = 0; b < 48; b++) begin
        vb[b] = ($urandom_range(0, 3) != 0);
        db[b] = 1'($urandom);
        cb[b] = ($urandom_range(0, 31) == 0);
      end
      run_seq(vb, db, cb, 48);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_overlap_modes();
    test_mismatch_fallback();
    test_valid_gap();
    test_saturation_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_recognizer.md
Name: seq_recognizer

Overview:
- Parametrised serial-sequence recognizer; successor to the fixed 3-state recognizer FSM.
- Detects an arbitrary N-bit pattern (MSB received first) on a 1-bit synchronous serial input, with a qualifying valid strobe.
- Supports overlapping and non-overlapping match modes and keeps a saturating match counter.
- Sits between a serial data source and a status/interrupt consumer; the Mealy match output is kept for drop-in use.

Parameters:
N, 3, pattern length in bits; legal range 2..16.
PATTERN, 3'b011, N-bit pattern; PATTERN[N-1] is the first bit expected, PATTERN[0] the last.
OVERLAP, 1, 1 = after a match resume from the longest proper prefix-suffix of PATTERN; 0 = restart from empty.
COUNT_W, 8, width of match_count.

Ports:
clk  input  1  system clock; all state updates on falling edge.
reset  input  1  asynchronous, active-low reset; clears state and counter immediately while low.
valid  input  1  D is sampled only when high.
D  input  1  serial data bit.
clear  input  1  synchronous counter clear, sampled on falling edge.
Q  output  1  Mealy match: high combinationally while the current state and D complete PATTERN and valid=1.
match_count  output  COUNT_W  saturating number of matches since reset/clear.
state  output  $clog2(N)  current matched-prefix length k (debug).

Behaviour:
- State k = number of pattern bits currently matched, range 0..N-1; encodings >= N are illegal and force next state 0.
- Reset (reset low): k=0, match_count=0, asynchronously. Q then equals valid & D==PATTERN[0] only if k==N-1, so Q=0 in reset.
- Next-state rule, applied on each falling edge with valid=1 (expected bit e = PATTERN[N-1-k]):
  - D==e and k<N-1: k -> k+1.
  - D==e and k==N-1: match. k -> F(N) if OVERLAP=1, else 0. F(j) = length of the longest proper suffix of PATTERN's first j bits that is also a prefix of PATTERN.
  - D!=e: k -> length of the longest suffix of (first k pattern bits, then D) that is a prefix of PATTERN, and is < N.
  - Transitions are computed by elaboration-time function or generate logic from PATTERN; no runtime tables.
- valid=0: k holds, Q=0, and the counter does not increment (except for clear).
- Q = valid & (k==N-1) & (D==PATTERN[0]). Combinational, zero latency, Mealy.
- match_count: increments on a falling edge where Q=1; saturates at 2^COUNT_W-1 with no wrap.
- clear=1 on an edge sets match_count=0, regardless of a simultaneous match (clear wins). clear does not affect k.
- Reset asserted mid-pattern discards partial progress. The first edge after release evaluates from k=0.
- Defaults (N=3, PATTERN=011) reproduce the legacy recognizer exactly: 0 -> k1, 01 -> k2, then D=1 gives Q=1.

Test Plan:
1. Defaults, valid=1, D stream 1,0,1,1,0,1,1 -> Q high during the bit-4 and bit-7 D=1 cycles; match_count=2; state sequence 0,0,1,2,0,1,2,0.
2. N=4, PATTERN=1010, stream 1,0,1,0,1,0,1,0:
   - OVERLAP=1 -> matches at bits 4, 6 and 8; count=3.
   - OVERLAP=0 -> matches at bits 4 and 8; count=2.
3. N=4, PATTERN=1101: stream 1,1,1,0,1 -> k goes 1,2,2,3, then match on bit 5. Stream 1,1,0,0 -> k ends at 0.
4. Defaults: drive 0, then 1 with valid=1; hold valid=0 for 5 cycles with D toggling (k stays 2, Q=0); then valid=1, D=1 -> Q=1, count=1.
5. COUNT_W=2, 5 matches -> match_count sticks at 3. Assert clear on the same edge as a 6th match -> match_count=0.
6. Defaults at k=2: pulse reset low between edges -> k=0 and count=0 immediately. After release, D=1 -> Q=0 and k=0.
